// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared load/store size encodings and LSU state type
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_STATE_IDLE = 2'd0,
        LSU_STATE_BUSY = 2'd1,
        LSU_STATE_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte enables, store lane replication and load extension
module lsu_data_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wd_i;
        rdata_o = 32'd0;
        err_o   = 1'b0;
        case (size_i)
            LDST_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            LDST_BU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
                rdata_o = {24'd0, byte_sel};
            end
            LDST_H: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
                err_o   = off_i[0];
            end
            LDST_HU: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
                rdata_o = {16'd0, half_sel};
                err_o   = off_i[0];
            end
            LDST_W: begin
                be_o    = 4'b1111;
                rdata_o = rword_i;
                err_o   = (off_i != 2'd0);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - single-outstanding load/store unit with ready handshake and timeout
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wd_q, mem_wd_d;
    logic [31:0]      core_rd_q, core_rd_d;
    logic             err_q, err_d;

    logic [2:0]  al_size;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_err;

    // In IDLE the aligner sees the live request; afterwards it works from the latched copy.
    assign al_size = (state_q == LSU_STATE_IDLE) ? core_size_i      : size_q;
    assign al_off  = (state_q == LSU_STATE_IDLE) ? core_addr_i[1:0] : off_q;

    lsu_data_align u_align (
        .size_i  (al_size),
        .off_i   (al_off),
        .wd_i    (core_wd_i),
        .rword_i (mem_rd_i),
        .be_o    (al_be),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata),
        .err_o   (al_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        off_d      = off_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        core_rd_d  = 32'd0;
        err_d      = 1'b0;
        unique case (state_q)
            LSU_STATE_IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    off_d  = core_addr_i[1:0];
                    cnt_d  = '0;
                    if (al_err) begin
                        state_d = LSU_STATE_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = LSU_STATE_BUSY;
                        mem_req_d  = 1'b1;
                        mem_we_d   = core_we_i;
                        mem_be_d   = al_be;
                        mem_addr_d = {core_addr_i[31:2], 2'b00};
                        mem_wd_d   = al_wdata;
                    end
                end
            end
            LSU_STATE_BUSY: begin
                // Ready is tested first so a response on the final cycle still counts.
                if (mem_ready_i) begin
                    state_d   = LSU_STATE_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                    core_rd_d = we_q ? 32'd0 : al_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LSU_STATE_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_STATE_DONE: state_d = LSU_STATE_IDLE;
            default:        state_d = LSU_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= LSU_STATE_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'd0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
            core_rd_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            off_q      <= off_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            core_rd_q  <= core_rd_d;
            err_q      <= err_d;
        end
    end

    assign core_stall_req_o = core_req_i & (state_q != LSU_STATE_DONE);
    assign core_rd_o        = core_rd_q;
    assign lsu_err_o        = err_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_be_o         = mem_be_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wd_o         = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd;
    logic        stall;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .core_req_i       (core_req),
        .core_we_i        (core_we),
        .core_size_i      (core_size),
        .core_addr_i      (core_addr),
        .core_wd_i        (core_wd),
        .core_rd_o        (core_rd),
        .core_stall_req_o (stall),
        .lsu_err_o        (lsu_err),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_be_o         (mem_be),
        .mem_addr_o       (mem_addr),
        .mem_wd_o         (mem_wd),
        .mem_rd_i         (mem_rd),
        .mem_ready_i      (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, "mem_req", 32'(mem_req), 32'd0);
        chk(tag, "core_rd", core_rd, 32'd0);
        chk(tag, "lsu_err", 32'(lsu_err), 32'd0);
    endtask

    // busy_cycles = 0 means the request must go straight to DONE with no memory access.
    task automatic access(input string tag, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                          input int busy_cycles, input int ready_cyc,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = addr; core_wd = wd;
        mem_ready = 1'b0; mem_rd = 32'd0;
        #1;
        chk(tag, "stall_idle", 32'(stall), 32'd1);
        chk(tag, "req_idle", 32'(mem_req), 32'd0);
        for (int c = 1; c <= busy_cycles; c++) begin
            @(negedge clk);
            chk(tag, "busy_req", 32'(mem_req), 32'd1);
            chk(tag, "busy_stall", 32'(stall), 32'd1);
            chk(tag, "busy_we", 32'(mem_we), 32'(we));
            chk(tag, "busy_be", 32'(mem_be), 32'(exp_be));
            chk(tag, "busy_addr", mem_addr, {addr[31:2], 2'b00});
            chk(tag, "busy_wd", mem_wd, exp_wd);
            if (c == ready_cyc) begin
                mem_ready = 1'b1;
                mem_rd = rword;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rd = 32'hDEAD_0000;
        chk(tag, "done_stall", 32'(stall), 32'd0);
        chk(tag, "done_req", 32'(mem_req), 32'd0);
        chk(tag, "done_rd", core_rd, exp_rd);
        chk(tag, "done_err", 32'(lsu_err), 32'(exp_err));
        core_req = 1'b0;
        @(negedge clk);
        chk_idle_outputs({tag, "_after"});
        chk(tag, "after_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        #2;
        chk_idle_outputs("reset");
        chk("reset", "mem_be", 32'(mem_be), 32'd0);
        chk("reset", "mem_addr", mem_addr, 32'd0);
        chk("reset", "mem_wd", mem_wd, 32'd0);
        chk("reset", "stall", 32'(stall), 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        access("lb",   1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1, 1, 4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0);
        access("lbu",  1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1, 1, 4'b1000, 32'd0, 32'h0000_0080, 1'b0);
        access("lhu",  1'b0, 3'd5, 32'h0000_2002, 32'd0, 32'h9ABC_0000, 1, 1, 4'b1100, 32'd0, 32'h0000_9ABC, 1'b0);
        access("lh",   1'b0, 3'd1, 32'h0000_2002, 32'd0, 32'h9ABC_0000, 1, 1, 4'b1100, 32'd0, 32'hFFFF_9ABC, 1'b0);
        access("lh0",  1'b0, 3'd1, 32'h0000_2000, 32'd0, 32'h1234_8001, 2, 2, 4'b0011, 32'd0, 32'hFFFF_8001, 1'b0);
        access("lw",   1'b0, 3'd2, 32'h0000_0004, 32'd0, 32'h89AB_CDEF, 1, 1, 4'b1111, 32'd0, 32'h89AB_CDEF, 1'b0);
        access("sb",   1'b1, 3'd0, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 3, 3, 4'b0010, 32'hA5A5_A5A5, 32'd0, 1'b0);
        access("sh",   1'b1, 3'd1, 32'h0000_0002, 32'h0000_CAFE, 32'd0, 1, 1, 4'b1100, 32'hCAFE_CAFE, 32'd0, 1'b0);
        access("sw",   1'b1, 3'd2, 32'h0000_0040, 32'h0BAD_F00D, 32'd0, 1, 1, 4'b1111, 32'h0BAD_F00D, 32'd0, 1'b0);
        access("lwmis", 1'b0, 3'd2, 32'h0000_0006, 32'd0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 1'b1);
        access("lhmis", 1'b0, 3'd5, 32'h0000_0003, 32'd0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 1'b1);
        access("sz3",  1'b0, 3'd3, 32'h0000_0008, 32'd0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0, 1'b1);
        access("tmo",  1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'd0, 4, 0, 4'b1111, 32'd0, 32'd0, 1'b1);
        access("last", 1'b0, 3'd2, 32'h0000_0014, 32'd0, 32'h5555_AAAA, 4, 4, 4'b1111, 32'd0, 32'h5555_AAAA, 1'b0);

        // Reset mid-BUSY clears outputs without a clock edge; the held request then restarts.
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h0000_0100; core_wd = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst", "busy_req", 32'(mem_req), 32'd1);
        chk("rst", "busy_wd", mem_wd, 32'hDEAD_BEEF);
        #2 arstn = 1'b0;
        #1;
        chk("rst", "req", 32'(mem_req), 32'd0);
        chk("rst", "we", 32'(mem_we), 32'd0);
        chk("rst", "be", 32'(mem_be), 32'd0);
        chk("rst", "addr", mem_addr, 32'd0);
        chk("rst", "wd", mem_wd, 32'd0);
        chk("rst", "stall", 32'(stall), 32'd1);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("restart", "req", 32'(mem_req), 32'd1);
        chk("restart", "addr", mem_addr, 32'h0000_0100);
        chk("restart", "wd", mem_wd, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("restart", "done_stall", 32'(stall), 32'd0);
        chk("restart", "done_err", 32'(lsu_err), 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        chk_idle_outputs("restart_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit: the responder to the decoder's memory control outputs (mem_req, mem_we, mem_size).
- Accepts one core request at a time and drives a word-wide data memory port with a ready handshake.
- Generates byte enables, replicates store data, and sign/zero-extends load data.
- Stalls the core until the access completes; flags misaligned, illegal-size and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in BUSY waiting for mem_ready_i before the access is aborted with an error. Must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- arstn_i  in  1  reset; asynchronous, active-low.
- core_req_i  in  1  access request (decoder mem_req).
- core_we_i  in  1  1 = store, 0 = load (decoder mem_we).
- core_size_i  in  3  LDST_B/H/W/BU/HU (decoder mem_size).
- core_addr_i  in  32  byte address from the ALU.
- core_wd_i  in  32  store data (rs2).
- core_rd_o  out  32  extended load data; valid only in DONE.
- core_stall_req_o  out  1  hold the pipeline.
- lsu_err_o  out  1  misaligned, illegal size or timeout; valid only in DONE.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word address, bits [1:0] = 0.
- mem_wd_o  out  32  lane-replicated store data.
- mem_rd_i  in  32  read word; valid when mem_ready_i = 1.
- mem_ready_i  in  1  access complete this cycle.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, arstn_i = 0):
  - state = IDLE, timeout counter = 0.
  - All registered outputs = 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, lsu_err_o.
  - Asserting reset in BUSY abandons the access immediately.
- core_stall_req_o = core_req_i & (state != DONE). Combinational; low whenever core_req_i is low.
- Core protocol: while stalled, the core holds core_req_i, we, size, addr and wd stable.
- IDLE with core_req_i = 1:
  - Latch we, size, addr[1:0] and the word address.
  - Illegal size (3, 6, 7), or H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0: go to DONE with lsu_err_o = 1 and core_rd_o = 0. No memory transaction.
  - Otherwise go to BUSY. mem_req_o = 1 from the next cycle; mem_we_o, mem_be_o, mem_addr_o, mem_wd_o are registered and held constant throughout BUSY.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- BUSY:
  - Counter increments each cycle.
  - mem_ready_i = 1: capture mem_rd_i into the data register, drop mem_req_o, go to DONE with lsu_err_o = 0.
  - Counter reaches TIMEOUT_CYCLES without ready: drop mem_req_o, go to DONE with lsu_err_o = 1 and core_rd_o = 0.
  - If ready and timeout occur in the same cycle, ready wins.
- DONE, exactly one cycle:
  - Stall released; core_rd_o is the extended captured data. Stores also present 0.
  - Next state IDLE; lsu_err_o and core_rd_o return to 0.
  - A new core_req_i seen in IDLE the following cycle starts the next access. Back-to-back accesses therefore take ≥3 cycles each.
- core_req_i dropped in BUSY: the access still completes (no abort on the memory side). The result is presented in DONE and ignored.
- Load extraction uses the latched addr[1:0]:
  - B: sign-extend the selected byte. BU: zero-extend it.
  - H: sign-extend the half selected by addr[1]. HU: zero-extend it.
  - W: full word.
- Minimum latency with mem_ready_i in the first BUSY cycle: 2 stall cycles, then DONE.

Decomposition:
- The LDST_* size encodings already exist in the shared defines header. Add LSU_STATE_IDLE/BUSY/DONE there as well.
- One sub-module, lsu_data_align (combinational): from size and addr[1:0] it produces be and replicated wdata, and from size, addr[1:0] and the raw word it produces extended rdata. It also produces a misaligned/illegal flag.

Test Plan:
- LB at 0x1003, mem_rd_i = 0x80FF_1234, ready on first BUSY cycle → mem_addr_o = 0x1000, mem_be_o = 4'b1000, stall high 2 cycles, DONE core_rd_o = 0xFFFF_FF80, lsu_err_o = 0.
- LHU at 0x2002, mem_rd_i = 0x9ABC_0000 → mem_be_o = 4'b1100, core_rd_o = 0x0000_9ABC. LH, same inputs → core_rd_o = 0xFFFF_9ABC.
- SB at 0x0001, wd = 0x1234_56A5, ready after 3 cycles → mem_we_o = 1, mem_be_o = 4'b0010, mem_wd_o = 0xA5A5_A5A5, all held stable through BUSY, stall released in DONE.
- LW at 0x0006 → no mem_req_o pulse; DONE next cycle with lsu_err_o = 1 and core_rd_o = 0. Size = 3'd3 at an aligned address → same response.
- TIMEOUT_CYCLES = 4, mem_ready_i tied low → mem_req_o high exactly 4 cycles, then DONE with lsu_err_o = 1, then IDLE.
- arstn_i pulsed low mid-BUSY → all outputs 0 immediately (asynchronously), state IDLE. A held core_req_i restarts the access after reset release.
